// File: rtl/tbird_button_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// tbird_button_conditioner_pkg
//   Shared definitions for the tbird button front end: the mode encoding seen
//   by the tbird sequencer and the button arbitration function.
// ----------------------------------------------------------------------------
package tbird_button_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_LEFT   = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    // pressed = {hazard, left, right}, active-high.
    // Left and right together are treated as a hazard request.
    function automatic mode_e arbitrate(input logic [2:0] pressed);
        mode_e target;
        if (pressed[2] || (pressed[1] && pressed[0])) begin
            target = MODE_HAZARD;
        end else if (pressed[1]) begin
            target = MODE_LEFT;
        end else if (pressed[0]) begin
            target = MODE_RIGHT;
        end else begin
            target = MODE_IDLE;
        end
        return target;
    endfunction

endpackage

// File: rtl/tbird_button_conditioner_debounce.sv
// ----------------------------------------------------------------------------
// tbird_button_conditioner_debounce
//   One button channel: two-flop synchroniser followed by a debounce counter
//   that accepts a new level only after DEBOUNCE_CYCLES consecutive clocks of
//   disagreement with the current stable level.
// Ports
//   clock     in  1  system clock
//   reset     in  1  asynchronous active-high reset
//   raw_n     in  1  raw active-low button, asynchronous to clock
//   level_n   out 1  debounced active-low level (1 = released)
// ----------------------------------------------------------------------------
module tbird_button_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level_n
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                // Disagreement has lasted DEBOUNCE_CYCLES clocks: accept it.
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Agreement (including a bounce back) leaves cnt_d at zero.
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_n = stable_q;

endmodule

// File: rtl/tbird_button_conditioner.sv
// ----------------------------------------------------------------------------
// tbird_button_conditioner
//   Front end for the tbird tail-light sequencer. Debounces the three raw
//   active-low buttons, arbitrates between them and holds the winner in a
//   registered mode FSM that drives mutually exclusive active-low requests.
// Ports
//   clock          in  1  system clock
//   reset          in  1  asynchronous active-high reset
//   right_button   in  1  raw right button, active-low
//   left_button    in  1  raw left button, active-low
//   hazard_button  in  1  raw hazard button, active-low
//   right_req_n    out 1  clean right request, active-low
//   left_req_n     out 1  clean left request, active-low
//   hazard_req_n   out 1  clean hazard request, active-low
//   mode           out 2  current mode: 0 IDLE, 1 RIGHT, 2 LEFT, 3 HAZARD
//   mode_change    out 1  one-cycle pulse when mode takes a new value
// ----------------------------------------------------------------------------
module tbird_button_conditioner
    import tbird_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       right_button,
    input  logic       left_button,
    input  logic       hazard_button,
    output logic       right_req_n,
    output logic       left_req_n,
    output logic       hazard_req_n,
    output logic [1:0] mode,
    output logic       mode_change
);

    logic right_lvl_n, left_lvl_n, hazard_lvl_n;

    tbird_button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clock   (clock),
        .reset   (reset),
        .raw_n   (right_button),
        .level_n (right_lvl_n)
    );

    tbird_button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clock   (clock),
        .reset   (reset),
        .raw_n   (left_button),
        .level_n (left_lvl_n)
    );

    tbird_button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hazard (
        .clock   (clock),
        .reset   (reset),
        .raw_n   (hazard_button),
        .level_n (hazard_lvl_n)
    );

    mode_e mode_q, mode_d;
    logic  mode_change_q, mode_change_d;
    logic  right_req_n_q, right_req_n_d;
    logic  left_req_n_q, left_req_n_d;
    logic  hazard_req_n_q, hazard_req_n_d;
    mode_e target;

    always_comb begin
        target = arbitrate(~{hazard_lvl_n, left_lvl_n, right_lvl_n});
        mode_d = target;
        // A direct swap between turn directions passes through IDLE for one
        // clock so tbird restarts its sequence from the first lamp.
        if ((mode_q == MODE_RIGHT && target == MODE_LEFT) ||
            (mode_q == MODE_LEFT  && target == MODE_RIGHT)) begin
            mode_d = MODE_IDLE;
        end
        mode_change_d  = (mode_d != mode_q);
        right_req_n_d  = (mode_d != MODE_RIGHT);
        left_req_n_d   = (mode_d != MODE_LEFT);
        hazard_req_n_d = (mode_d != MODE_HAZARD);
    end

    // Outputs are registered from the next state so they change on the same
    // edge as mode and can never glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q         <= MODE_IDLE;
            mode_change_q  <= 1'b0;
            right_req_n_q  <= 1'b1;
            left_req_n_q   <= 1'b1;
            hazard_req_n_q <= 1'b1;
        end else begin
            mode_q         <= mode_d;
            mode_change_q  <= mode_change_d;
            right_req_n_q  <= right_req_n_d;
            left_req_n_q   <= left_req_n_d;
            hazard_req_n_q <= hazard_req_n_d;
        end
    end

    assign mode         = mode_q;
    assign mode_change  = mode_change_q;
    assign right_req_n  = right_req_n_q;
    assign left_req_n   = left_req_n_q;
    assign hazard_req_n = hazard_req_n_q;

endmodule

// File: tb/tb_tbird_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_tbird_button_conditioner
//   Directed and randomized stimulus for tbird_button_conditioner with
//   DEBOUNCE_CYCLES = 8, compared every clock against a reference model that
//   keeps the history of raw samples and applies the debounce and mode rules.
// ----------------------------------------------------------------------------
module tb_tbird_button_conditioner;

    localparam int DC = 8;

    logic       clock;
    logic       reset;
    logic       right_button, left_button, hazard_button;
    logic       right_req_n, left_req_n, hazard_req_n;
    logic [1:0] mode;
    logic       mode_change;

    int checks = 0;
    int errors = 0;

    tbird_button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clock         (clock),
        .reset         (reset),
        .right_button  (right_button),
        .left_button   (left_button),
        .hazard_button (hazard_button),
        .right_req_n   (right_req_n),
        .left_req_n    (left_req_n),
        .hazard_req_n  (hazard_req_n),
        .mode          (mode),
        .mode_change   (mode_change)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: raw samples per edge (index 0 newest),
    // accepted levels {hazard,left,right}, mode and mode_change.
    logic [2:0] hist [0:15];
    logic [2:0] stab;
    logic [1:0] m_mode;
    logic       m_mc;

    function automatic logic [1:0] pick(input logic [2:0] p);
        if (p[2] || (p[1] && p[0])) return 2'd3;
        if (p[1]) return 2'd2;
        if (p[0]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) hist[i] = 3'b111;
        stab   = 3'b111;
        m_mode = 2'd0;
        m_mc   = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] t;
        logic [1:0] nm;
        logic       flip;
        t  = pick(~stab);
        nm = t;
        if ((m_mode == 2'd1 && t == 2'd2) || (m_mode == 2'd2 && t == 2'd1)) nm = 2'd0;
        m_mc   = (nm != m_mode);
        m_mode = nm;
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {hazard_button, left_button, right_button};
        // Synchronised value seen at this edge is the raw sample from two
        // edges ago; a level is accepted once DC consecutive synchronised
        // samples disagree with it.
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int i = 2; i < DC + 2; i++) if (hist[i][b] == stab[b]) flip = 1'b0;
            if (flip) stab[b] = ~stab[b];
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("mode", {2'b00, mode}, {2'b00, m_mode});
        chk("req_n", {1'b0, hazard_req_n, left_req_n, right_req_n},
            {1'b0, m_mode != 2'd3, m_mode != 2'd2, m_mode != 2'd1});
        chk("mode_change", {3'b000, mode_change}, {3'b000, m_mc});
        chk("exclusive", 4'($countones({~hazard_req_n, ~left_req_n, ~right_req_n}) <= 1), 4'd1);
    endtask

    // One clock: advance model at the edge, sample DUT 1 time unit later.
    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        right_button = 1'b1; left_button = 1'b1; hazard_button = 1'b1;
        reset = 1'b0;
        model_reset();

        // 1. Reset state, held for 5 clocks
        #2 reset = 1'b1;
        #1;
        chk("reset_mode", {2'b00, mode}, 4'd0);
        chk("reset_req", {1'b0, hazard_req_n, left_req_n, right_req_n}, 4'b0111);
        chk("reset_mc", {3'b000, mode_change}, 4'd0);
        ticks(5);
        reset = 1'b0;
        ticks(3);

        // 2. Right press and release latency
        right_button = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) chk("right_lat_early", {3'b000, right_req_n}, 4'd1);
        end
        chk("right_lat", {3'b000, right_req_n}, 4'd0);
        chk("right_mode", {2'b00, mode}, 4'd1);
        chk("right_pulse", {3'b000, mode_change}, 4'd1);
        tick();
        chk("right_pulse_end", {3'b000, mode_change}, 4'd0);
        ticks(4);
        right_button = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) chk("rel_lat_early", {3'b000, right_req_n}, 4'd0);
        end
        chk("rel_lat", {3'b000, right_req_n}, 4'd1);
        chk("rel_mode", {2'b00, mode}, 4'd0);
        ticks(3);

        // 3. Bouncing left, then held
        for (int k = 0; k < 10; k++) begin
            left_button = (k % 2 == 0) ? 1'b0 : 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("bounce_left", {3'b000, left_req_n}, 4'd1);
            end
        end
        left_button = 1'b0;
        ticks(11);
        chk("left_lat", {3'b000, left_req_n}, 4'd0);
        chk("left_mode", {2'b00, mode}, 4'd2);
        left_button = 1'b1;
        ticks(20);

        // 4a. RIGHT then hazard: direct transition
        right_button = 1'b0;
        ticks(13);
        hazard_button = 1'b0;
        ticks(11);
        chk("haz_req", {1'b0, hazard_req_n, left_req_n, right_req_n}, 4'b0011);
        chk("haz_mode", {2'b00, mode}, 4'd3);
        right_button = 1'b1; hazard_button = 1'b1;
        ticks(20);

        // 4b. Left and right together from IDLE
        left_button = 1'b0; right_button = 1'b0;
        ticks(11);
        chk("lr_mode", {2'b00, mode}, 4'd3);
        left_button = 1'b1; right_button = 1'b1;
        ticks(20);

        // 5. RIGHT -> LEFT through one IDLE cycle
        right_button = 1'b0;
        ticks(14);
        right_button = 1'b1; left_button = 1'b0;
        ticks(10);
        chk("swap_hold", {2'b00, mode}, 4'd1);
        tick();
        chk("swap_idle", {2'b00, mode}, 4'd0);
        chk("swap_pulse1", {3'b000, mode_change}, 4'd1);
        tick();
        chk("swap_left", {2'b00, mode}, 4'd2);
        chk("swap_pulse2", {3'b000, mode_change}, 4'd1);
        ticks(3);

        // 6. Async reset mid-debounce while in LEFT
        hazard_button = 1'b0;
        ticks(7);
        #2 reset = 1'b1;
        #1;
        chk("async_req", {1'b0, hazard_req_n, left_req_n, right_req_n}, 4'b0111);
        chk("async_mode", {2'b00, mode}, 4'd0);
        chk("async_mc", {3'b000, mode_change}, 4'd0);
        hazard_button = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) chk("post_rst_early", {3'b000, left_req_n}, 4'd1);
        end
        chk("post_rst_lat", {3'b000, left_req_n}, 4'd0);
        left_button = 1'b1;
        ticks(20);

        // Randomized segments with occasional bouncing
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                int nb;
                nb = $urandom_range(1, 5);
                for (int k = 0; k < nb; k++) begin
                    {hazard_button, left_button, right_button} = 3'($urandom);
                    ticks($urandom_range(1, 4));
                end
            end
            {hazard_button, left_button, right_button} = 3'($urandom_range(0, 7));
            ticks($urandom_range(1, 24));
        end
        {hazard_button, left_button, right_button} = 3'b111;
        ticks(20);
        chk("final_idle", {2'b00, mode}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
